// File: rtl/rv32_mvu_sched.sv
`default_nettype none
// ============================================================================
// Module   : rv32_mvu_sched
// Brief    : Round-robin scheduler sharing one MVU among the barrel-core
//            harts. Per-hart start pulses are queued as pending flags, one
//            winner at a time gets its descriptor latched and launched, and
//            the MVU completion is returned as a one-cycle irq to the owner.
// Options  : MVU_SCHED_TIMEOUT_EN - adds a BUSY watchdog that aborts a job
//            after TIMEOUT_CYC cycles and pulses timeout_err.
// Revision : 1.0 - initial release
// ============================================================================
module rv32_mvu_sched #(
  parameter  int NUM_HARTS   = 8,
  parameter  int CFG_W       = 512,
  parameter  int TIMEOUT_CYC = 65536,
  localparam int HID_W       = $clog2(NUM_HARTS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_HARTS-1:0]       hart_start,
  input  logic [NUM_HARTS*CFG_W-1:0] hart_cfg,
  input  logic                       mvu_done,
  output logic                       mvu_start,
  output logic [CFG_W-1:0]           mvu_cfg,
  output logic [NUM_HARTS-1:0]       hart_irq,
  output logic [NUM_HARTS-1:0]       hart_pending,
  output logic [HID_W-1:0]           active_hart,
  output logic                       sched_busy,
  output logic                       timeout_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    BUSY   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t               r_state;
  logic [NUM_HARTS-1:0] r_pending;
  logic [NUM_HARTS-1:0] r_irq;
  logic [HID_W-1:0]     r_ptr;
  logic [HID_W-1:0]     r_active;
  logic [CFG_W-1:0]     r_mvu_cfg;
  logic                 r_mvu_start;
  logic                 r_timeout_err;

  logic [CFG_W-1:0]     w_cfg_arr [NUM_HARTS];
  logic [HID_W-1:0]     w_scan_idx;
  logic [HID_W-1:0]     w_winner;
  logic                 w_found;
  logic [NUM_HARTS-1:0] w_grant_vec;
  logic [HID_W-1:0]     w_next_ptr;
  logic                 w_timeout_hit;

  // Split the flat descriptor bus into one entry per hart.
  for (genvar h = 0; h < NUM_HARTS; h++) begin : g_cfg_unpack
    assign w_cfg_arr[h] = hart_cfg[h*CFG_W +: CFG_W];
  end

  // Round-robin scan: walk from the farthest offset back to ptr so the
  // pending hart closest to ptr (in wrap order) is the last one written.
  always_comb begin
    w_found    = 1'b0;
    w_winner   = '0;
    w_scan_idx = '0;
    for (int i = NUM_HARTS - 1; i >= 0; i--) begin
      w_scan_idx = HID_W'((int'(r_ptr) + i) % NUM_HARTS);
      if (r_pending[w_scan_idx]) begin
        w_found  = 1'b1;
        w_winner = w_scan_idx;
      end
    end
  end

  // One-hot clear mask for the hart granted this cycle (only from IDLE).
  always_comb begin
    w_grant_vec = '0;
    if ((r_state == IDLE) && w_found) begin
      w_grant_vec[w_winner] = 1'b1;
    end
  end

  assign w_next_ptr = (r_active == HID_W'(NUM_HARTS - 1)) ? '0 : r_active + 1'b1;

`ifdef MVU_SCHED_TIMEOUT_EN
  localparam int                c_TO_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYC - 1);

  logic [c_TO_W-1:0] r_to_cnt;

  // Watchdog: restarts as the job enters BUSY, counts every BUSY cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
    end else if (r_state == LAUNCH) begin
      r_to_cnt <= '0;
    end else if (r_state == BUSY) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign w_timeout_hit = (r_to_cnt == c_TO_LAST);
`else
  // Watchdog compiled out: BUSY waits for mvu_done indefinitely.
  assign w_timeout_hit = 1'b0;
`endif

  // Scheduler FSM with pending queue and registered MVU/hart outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_pending     <= '0;
      r_ptr         <= '0;
      r_active      <= '0;
      r_mvu_cfg     <= '0;
      r_mvu_start   <= 1'b0;
      r_irq         <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      // A start in the grant cycle of the same hart is absorbed by the clear.
      r_pending     <= (r_pending | hart_start) & ~w_grant_vec;
      r_mvu_start   <= 1'b0;
      r_irq         <= '0;
      r_timeout_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            // Descriptor is captured at grant, not at the start request.
            r_active    <= w_winner;
            r_mvu_cfg   <= w_cfg_arr[w_winner];
            r_mvu_start <= 1'b1;
            r_state     <= LAUNCH;
          end
        end
        LAUNCH: begin
          r_state <= BUSY;
        end
        BUSY: begin
          if (mvu_done) begin
            r_irq[r_active] <= 1'b1;
            r_state         <= DONE;
          end else if (w_timeout_hit) begin
            r_irq[r_active] <= 1'b1;
            r_timeout_err   <= 1'b1;
            r_state         <= DONE;
          end
        end
        DONE: begin
          r_ptr   <= w_next_ptr;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign mvu_start    = r_mvu_start;
  assign mvu_cfg      = r_mvu_cfg;
  assign hart_irq     = r_irq;
  assign hart_pending = r_pending;
  assign active_hart  = r_active;
  assign sched_busy   = (r_state != IDLE);
  assign timeout_err  = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_rv32_mvu_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32_mvu_sched
// Brief    : Self-checking bench for rv32_mvu_sched. A timestamp-based job
//            model predicts every output each cycle; directed scenarios add
//            literal checks on grant order, latencies and irq values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32_mvu_sched;

  localparam int NH = 8;
  localparam int CW = 512;
  localparam int TO = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NH-1:0]    hart_start;
  logic [NH*CW-1:0] hart_cfg;
  logic             mvu_done;
  logic             mvu_start;
  logic [CW-1:0]    mvu_cfg;
  logic [NH-1:0]    hart_irq;
  logic [NH-1:0]    hart_pending;
  logic [2:0]       active_hart;
  logic             sched_busy;
  logic             timeout_err;

  rv32_mvu_sched #(
    .NUM_HARTS  (NH),
    .CFG_W      (CW),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hart_start  (hart_start),
    .hart_cfg    (hart_cfg),
    .mvu_done    (mvu_done),
    .mvu_start   (mvu_start),
    .mvu_cfg     (mvu_cfg),
    .hart_irq    (hart_irq),
    .hart_pending(hart_pending),
    .active_hart (active_hart),
    .sched_busy  (sched_busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A job is described by the cycle it was granted and the cycle its
  // completion (or abort) was seen; every output follows from those stamps.
  bit [NH-1:0] m_pend;
  int          m_ptr, m_hart, m_gcyc, m_dcyc, m_k, m_w;
  bit          m_job, m_found;
  logic [CW-1:0] m_cfg;
  bit [NH-1:0] m_nxt, e_irq;
  bit          e_start, e_to;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend = '0; m_ptr = 0; m_hart = 0; m_gcyc = 0; m_dcyc = -1;
      m_job = 1'b0; m_cfg = '0; e_irq = '0; e_start = 1'b0; e_to = 1'b0;
    end else begin
      m_k = cyc;
      e_start = 1'b0; e_irq = '0; e_to = 1'b0;
      m_nxt = m_pend | hart_start;
      if (m_job) begin
        if (m_dcyc < 0 && m_k >= m_gcyc + 2) begin
          if (mvu_done) m_dcyc = m_k;
`ifdef MVU_SCHED_TIMEOUT_EN
          else if (m_k - (m_gcyc + 2) == TO - 1) begin
            m_dcyc = m_k;
            e_to   = 1'b1;
          end
`endif
          if (m_dcyc == m_k) e_irq[m_hart] = 1'b1;
        end else if (m_dcyc >= 0 && m_k == m_dcyc + 1) begin
          m_job = 1'b0;
          m_ptr = (m_hart + 1) % NH;
        end
      end else if (m_pend != '0) begin
        m_found = 1'b0; m_w = 0;
        for (int i = 0; i < NH; i++) begin
          if (!m_found && m_pend[(m_ptr + i) % NH]) begin
            m_found = 1'b1;
            m_w     = (m_ptr + i) % NH;
          end
        end
        m_hart = m_w;
        m_cfg  = hart_cfg[m_w*CW +: CW];
        m_job  = 1'b1;
        m_gcyc = m_k;
        m_dcyc = -1;
        m_nxt[m_w] = 1'b0;
        e_start = 1'b1;
      end
      m_pend = m_nxt;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("mvu_start",    mvu_start,    e_start);
      chk("hart_irq",     hart_irq,     e_irq);
      chk("timeout_err",  timeout_err,  e_to);
      chk("hart_pending", hart_pending, m_pend);
      chk("sched_busy",   sched_busy,   m_job);
      chk("active_hart",  active_hart,  m_hart);
      chk("mvu_cfg",      mvu_cfg,      m_cfg);
    end
  end

  // Event log for the directed literal checks.
  int            q_start_cyc[$];
  int            q_start_hart[$];
  logic [CW-1:0] q_start_cfg[$];
  int            q_irq_cyc[$];
  logic [NH-1:0] q_irq_val[$];
  int            q_to_cyc[$];

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      if (mvu_start) begin
        q_start_cyc.push_back(cyc);
        q_start_hart.push_back(int'(active_hart));
        q_start_cfg.push_back(mvu_cfg);
      end
      if (hart_irq != '0) begin
        q_irq_cyc.push_back(cyc);
        q_irq_val.push_back(hart_irq);
      end
      if (timeout_err) q_to_cyc.push_back(cyc);
    end
  end

  function automatic void clear_logs();
    q_start_cyc.delete(); q_start_hart.delete(); q_start_cfg.delete();
    q_irq_cyc.delete(); q_irq_val.delete(); q_to_cyc.delete();
  endfunction

  // Advance to cycle n; inputs change 2 time units after the edge.
  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_start(input int idx, output int sc);
    int lim;
    lim = cyc + 40;
    while (q_start_cyc.size() <= idx && cyc < lim) goto(cyc + 1);
    chk("mvu_start seen", 512'(q_start_cyc.size() > idx), 512'd1);
    sc = (q_start_cyc.size() > idx) ? q_start_cyc[idx] : cyc - 1;
  endtask

  task automatic run_job(input int idx, input int lat);
    int sc;
    wait_start(idx, sc);
    goto(sc + lat); mvu_done = 1'b1;
    goto(sc + lat + 1); mvu_done = 1'b0;
  endtask

  // Job whose BUSY window also carries new start requests.
  task automatic job_with_start(input int idx, input logic [NH-1:0] mask);
    int sc;
    wait_start(idx, sc);
    hart_start = mask; goto(sc + 2); hart_start = '0;
    goto(sc + 3); mvu_done = 1'b1;
    goto(sc + 4); mvu_done = 1'b0;
  endtask

  int            exp_h   [7] = '{1, 5, 6, 7, 0, 1, 0};
  logic [NH-1:0] exp_irq [7] = '{8'h02, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02, 8'h01};
  logic [CW-1:0] c_p1, c_p2;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int base, sc;
    rst_n = 1'b0; hart_start = '0; mvu_done = 1'b0; hart_cfg = '0;
    for (int h = 0; h < NH; h++) hart_cfg[h*CW +: CW] = {16{32'h1000_0000 + 32'(h)}};
    hart_cfg[3*CW +: CW] = {64{8'hA5}};
    c_p1 = {16{32'hDEAD_0002}};
    c_p2 = {16{32'hBEEF_0002}};
    repeat (3) @(posedge clk);
    #2; chk_en = 1'b1;

    // Reset values
    chk("rst mvu_start", mvu_start, 0);
    chk("rst mvu_cfg", mvu_cfg, 0);
    chk("rst hart_irq", hart_irq, 0);
    chk("rst pending", hart_pending, 0);
    chk("rst active", active_hart, 0);
    chk("rst busy", sched_busy, 0);
    chk("rst timeout", timeout_err, 0);
    rst_n = 1'b1;

    // Single job from hart 3
    base = cyc; clear_logs();
    goto(base + 10); hart_start = 8'h08;
    goto(base + 11); hart_start = '0;
    chk("single pending t+1", hart_pending, 8'h08);
    goto(base + 20); mvu_done = 1'b1;
    goto(base + 21); mvu_done = 1'b0;
    goto(base + 25);
    chk("single n_start", q_start_cyc.size(), 1);
    chk("single start cyc", q_start_cyc[0] - base, 12);
    chk("single cfg", q_start_cfg[0], {64{8'hA5}});
    chk("single n_irq", q_irq_cyc.size(), 1);
    chk("single irq cyc", q_irq_cyc[0] - base, 21);
    chk("single irq val", q_irq_val[0], 8'h08);

    // Asynchronous reset in the middle of a BUSY job with a loaded queue
    base = cyc; clear_logs();
    hart_start = 8'h10; goto(base + 1); hart_start = '0;
    goto(base + 4); hart_start = 8'h0F;
    goto(base + 5); hart_start = '0;
    goto(base + 6);
    chk("midrst pending", hart_pending, 8'h0F);
    chk("midrst busy", sched_busy, 1);
    rst_n = 1'b0; #1;
    chk("async mvu_start", mvu_start, 0);
    chk("async mvu_cfg", mvu_cfg, 0);
    chk("async irq", hart_irq, 0);
    chk("async pending", hart_pending, 0);
    chk("async active", active_hart, 0);
    chk("async busy", sched_busy, 0);
    chk("async timeout", timeout_err, 0);
    goto(base + 8); rst_n = 1'b1;
    goto(base + 9);
    chk("post-rst busy", sched_busy, 0);
    chk("post-rst pending", hart_pending, 0);

    // Arbitration 1,5,6 from ptr=0, then wrap 7 before 0, then ptr=1
    base = cyc; clear_logs();
    hart_start = 8'h62; goto(base + 1); hart_start = '0;
    run_job(0, 3);
    run_job(1, 3);
    job_with_start(2, 8'h81);
    run_job(3, 3);
    job_with_start(4, 8'h03);
    run_job(5, 1);
    run_job(6, 1);
    goto(cyc + 5);
    chk("arb n_start", q_start_cyc.size(), 7);
    chk("arb n_irq", q_irq_cyc.size(), 7);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("arb grant[%0d]", i), q_start_hart[i], exp_h[i]);
      chk($sformatf("arb irq[%0d]", i), q_irq_val[i], exp_irq[i]);
    end
    chk("arb first start", q_start_cyc[0] - base, 2);
    chk("arb done->start", q_start_cyc[1] - q_start_cyc[0], 6);
    chk("min slot", q_start_cyc[6] - q_start_cyc[5], 4);

    // Re-queue of the active hart, duplicate absorb, grant-cycle absorb
    clear_logs();
    hart_cfg[2*CW +: CW] = c_p1;
    hart_start = 8'h04; goto(cyc + 1); hart_start = '0;
    wait_start(0, sc);
    hart_start = 8'h04; goto(sc + 2); hart_start = '0;
    chk("requeue pending", hart_pending, 8'h04);
    hart_cfg[2*CW +: CW] = c_p2;
    hart_start = 8'h04; goto(sc + 3); hart_start = '0;
    chk("dup pending", hart_pending, 8'h04);
    mvu_done = 1'b1; goto(sc + 4); mvu_done = 1'b0;
    goto(sc + 5); hart_start = 8'h04;
    goto(sc + 6); hart_start = '0;
    chk("grant-cycle absorb", hart_pending, 8'h00);
    run_job(1, 2);
    goto(cyc + 10);
    chk("requeue n_start", q_start_cyc.size(), 2);
    chk("requeue cfg0", q_start_cfg[0], c_p1);
    chk("requeue cfg1", q_start_cfg[1], c_p2);
    chk("requeue regrant", q_start_cyc[1] - q_start_cyc[0], 6);
    chk("requeue n_irq", q_irq_cyc.size(), 2);
    chk("requeue irq1", q_irq_val[1], 8'h04);

`ifdef MVU_SCHED_TIMEOUT_EN
    // Watchdog abort, then a completion landing in the last counted cycle
    clear_logs();
    hart_start = 8'h20; goto(cyc + 1); hart_start = '0;
    wait_start(0, sc);
    goto(sc + 21);
    chk("to n_irq", q_irq_cyc.size(), 1);
    chk("to irq cyc", q_irq_cyc[0] - (sc + 1), 16);
    chk("to irq val", q_irq_val[0], 8'h20);
    chk("to n_err", q_to_cyc.size(), 1);
    chk("to err cyc", q_to_cyc[0] - (sc + 1), 16);
    hart_start = 8'h20; goto(cyc + 1); hart_start = '0;
    wait_start(1, sc);
    goto(sc + 16); mvu_done = 1'b1;
    goto(sc + 17); mvu_done = 1'b0;
    goto(sc + 22);
    chk("late done n_irq", q_irq_cyc.size(), 2);
    chk("late done irq cyc", q_irq_cyc[1] - (sc + 1), 16);
    chk("late done n_err", q_to_cyc.size(), 1);
`else
    // No watchdog: a job without mvu_done stays BUSY
    clear_logs();
    hart_start = 8'h20; goto(cyc + 1); hart_start = '0;
    wait_start(0, sc);
    goto(sc + 1001);
    chk("hang n_irq", q_irq_cyc.size(), 0);
    chk("hang busy", sched_busy, 1);
    chk("hang active", active_hart, 5);
    chk("hang n_err", q_to_cyc.size(), 0);
    mvu_done = 1'b1; goto(cyc + 1); mvu_done = 1'b0;
    goto(cyc + 4);
    chk("hang release n_irq", q_irq_cyc.size(), 1);
    chk("hang release irq", q_irq_val[0], 8'h20);
`endif

    goto(cyc + 3);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rv32_mvu_sched.md
# rv32_mvu_sched

Round-robin scheduler that shares one MVU among the harts of the barrel core. Per-hart start pulses and packed job descriptors from the barrel CSR files are queued, arbitrated, and launched one job at a time. Each job's completion is routed back as a one-cycle interrupt to the hart that issued it. The block sits between the barrel CSR file outputs and the single MVU instance.

## Interface
- NUM_HARTS, 8: number of harts/requesters; HID_W = $clog2(NUM_HARTS)
- CFG_W, 512: width of one packed MVU job descriptor (precisions, base addresses, strides, lengths, countdown, mul mode)
- TIMEOUT_CYC, 65536: watchdog limit in cycles; used only with MVU_SCHED_TIMEOUT_EN
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- hart_start  in  NUM_HARTS  one-cycle start request per hart
- hart_cfg  in  NUM_HARTS*CFG_W  job descriptor of hart h at [h*CFG_W +: CFG_W]
- mvu_done  in  1  one-cycle completion pulse from MVU
- mvu_start  out  1  one-cycle launch pulse to MVU
- mvu_cfg  out  CFG_W  registered descriptor of active job
- hart_irq  out  NUM_HARTS  one-cycle completion interrupt per hart
- hart_pending  out  NUM_HARTS  queued-but-not-granted flags
- active_hart  out  HID_W  hart owning the MVU
- sched_busy  out  1  high in any state other than IDLE
- timeout_err  out  1  one-cycle watchdog abort pulse (constant 0 without macro)

## Operation
- pending[h] is set on hart_start[h].
- pending[h] is cleared when h is granted.
- A start for an already-pending hart is absorbed: no double queueing.
- A start for the active hart sets pending, so the hart is re-queued.
- A start arriving in the same cycle the same hart is granted is absorbed.
- The descriptor is sampled at grant time, not at start. Software must hold its CSRs stable until hart_irq.
- FSM states: IDLE, LAUNCH, BUSY, DONE.
- IDLE, pending nonzero:
  - Winner = first pending index at or after ptr, wrapping modulo NUM_HARTS.
  - Register active_hart and mvu_cfg <= hart_cfg[winner].
  - Clear pending[winner] and go to LAUNCH.
- IDLE, pending zero: stay in IDLE.
- LAUNCH: mvu_start=1 for exactly one cycle, then go to BUSY.
- BUSY: stay until mvu_done=1, then go to DONE.
- mvu_done outside BUSY is ignored.
- DONE:
  - hart_irq[active_hart]=1 for one cycle.
  - ptr <= (active_hart+1) mod NUM_HARTS.
  - Go to IDLE.
- hart_irq is one-hot or zero, never multi-hot.
- mvu_cfg and active_hart hold their values after DONE until the next grant.

## Timing
- Reset values:
  - state=IDLE, ptr=0, pending=0, active_hart=0, mvu_cfg=0.
  - mvu_start=0, hart_irq=0, sched_busy=0, timeout_err=0.
- hart_start at cycle t: pending visible at t+1.
- From IDLE with an empty queue, a hart_start at cycle t produces the grant at t+1 and mvu_start at t+2.
- mvu_done at cycle d: hart_irq at d+1, IDLE at d+2, next grant at d+2, next mvu_start at d+3.
- Minimum job slot is 4 cycles: LAUNCH, BUSY with immediate done, DONE, IDLE.
- Reset mid-job: asynchronously returns to IDLE and drops all pending requests. The MVU shares rst_n.

## Configuration
- MVU_SCHED_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT_CYC) clears on BUSY entry and increments each cycle in BUSY.
  - If the count reaches TIMEOUT_CYC-1 without mvu_done, go to DONE.
  - In that DONE cycle, assert timeout_err and hart_irq[active_hart] together.
  - mvu_done in that same last cycle counts as normal completion: no timeout_err.
- MVU_SCHED_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely; timeout_err tied to 0.

## Test plan
- Reset:
  - Stimulus: assert rst_n=0 mid-BUSY with pending=8'h0F.
  - Response: all outputs and pending go to 0 immediately; first cycle after release is IDLE.
- Single job:
  - Stimulus: hart_start[3] at cycle 10 with hart_cfg[3]=512'hA5A5…, then mvu_done at cycle 20.
  - Response: mvu_start at 12, mvu_cfg=512'hA5A5… at 12, hart_irq=8'h08 at 21, nothing else asserted.
- Arbitration:
  - Stimulus: harts 1, 5 and 6 start in the same cycle with ptr=0; each job takes 5 cycles.
  - Response: grant order 1, 5, 6; hart_irq pulses 8'h02, 8'h20, 8'h40 in that order.
- Wrap fairness:
  - Stimulus: after hart 6 completes (ptr=7), harts 0 and 7 are pending.
  - Response: 7 is served before 0, then ptr=1.
- Re-queue:
  - Stimulus: hart_start[2] while hart 2 is BUSY.
  - Response: pending[2]=1; after hart_irq[2], hart 2 is re-granted with a fresh descriptor sample.
  - Stimulus: a duplicate start while pending.
  - Response: only one extra job.
- Timeout (macro on, TIMEOUT_CYC=16):
  - Stimulus: BUSY entered at cycle b, no mvu_done.
  - Response: timeout_err and hart_irq[active] at b+16.
  - Macro off: remains BUSY for 1000 cycles with no irq.
